// File: rtl/fcvt_result_writeback.sv
// Writeback stage behind the FCVT.S.D converter: 2-entry result FIFO with NaN canonicalisation
// and boxing, register-file write handshake, sticky fflags accumulation and a retired-result counter.
module fcvt_result_writeback #(
  parameter int BUS_WIDTH    = 64,
  parameter int RESULT_WIDTH = 32,
  parameter int RD_WIDTH     = 5,
  parameter int FLAG_WIDTH   = 5,
  parameter int CANON_NAN    = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RESULT_WIDTH-1:0] in_result,
  input  logic [RD_WIDTH-1:0]     in_rd,
  input  logic [FLAG_WIDTH-1:0]   in_flags,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BUS_WIDTH-1:0]    out_data,
  output logic [RD_WIDTH-1:0]     out_rd,
  input  logic                    fflags_clr,
  output logic [FLAG_WIDTH-1:0]   fflags_acc,
  output logic [CNT_WIDTH-1:0]    retired_cnt
);

  localparam int BOX_WIDTH = BUS_WIDTH - RESULT_WIDTH;
  localparam logic [RESULT_WIDTH-1:0] QNAN = RESULT_WIDTH'(32'h7fc00000);

  // slot 0 is always the head; slot 1 is only valid when count==2
  logic [1:0]                       count;
  logic [1:0][RESULT_WIDTH-1:0]     data_q;
  logic [1:0][RD_WIDTH-1:0]         rd_q;
  logic [1:0][FLAG_WIDTH-1:0]       flags_q;

  logic                    push;
  logic                    pop;
  logic                    is_nan;
  logic [RESULT_WIDTH-1:0] stored;

  assign in_ready  = (count != 2'd2) && !flush;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    is_nan = (&in_result[30:23]) && (|in_result[22:0]);
    stored = in_result;
    if ((CANON_NAN != 0) && is_nan) stored = QNAN;
  end

  assign out_data = out_valid ? {{BOX_WIDTH{1'b1}}, data_q[0]} : '0;
  assign out_rd   = out_valid ? rd_q[0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      data_q      <= '0;
      rd_q        <= '0;
      flags_q     <= '0;
      fflags_acc  <= '0;
      retired_cnt <= '0;
    end else begin
      if (pop) retired_cnt <= retired_cnt + 1'b1;

      // clear takes effect before the retiring entry's flags are merged
      if (fflags_clr)
        fflags_acc <= pop ? flags_q[0] : '0;
      else if (pop)
        fflags_acc <= fflags_acc | flags_q[0];

      if (flush) begin
        count <= 2'd0;
      end else if (push && pop) begin
        data_q[0]  <= stored;
        rd_q[0]    <= in_rd;
        flags_q[0] <= in_flags;
      end else if (push) begin
        if (count == 2'd0) begin
          data_q[0]  <= stored;
          rd_q[0]    <= in_rd;
          flags_q[0] <= in_flags;
        end else begin
          data_q[1]  <= stored;
          rd_q[1]    <= in_rd;
          flags_q[1] <= in_flags;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        data_q[0]  <= data_q[1];
        rd_q[0]    <= rd_q[1];
        flags_q[0] <= flags_q[1];
        count      <= count - 2'd1;
      end
    end
  end

endmodule
